// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with valid/ready byte input and global enable
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  // All next-state terms default to hold, so ena low freezes the frame in place.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    tx_n     = tx;
    tx_ready = (state == IDLE) && ena && !rst;
    busy     = (state != IDLE);
    done     = ena && (state == STOP) && bit_end;
    if (ena) begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state_n = START;
            shift_n = tx_data;
            cnt_n   = '0;
            idx_n   = '0;
            tx_n    = 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
            tx_n    = shift[0];
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_n   = '0;
            shift_n = shift >> 1;
            if (idx == 3'd7) begin
              state_n = STOP;
              tx_n    = 1'b1;
            end else begin
              idx_n = idx + 3'd1;
              tx_n  = shift[1];
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb/tb_uart_tx_8n1.sv - bench for uart_tx_8n1: N=4 and N=2 instances against a frame-position model
module tb_uart_tx_8n1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic rdy4, tx4, busy4, done4;
  logic rdy2, tx2, busy2, done2;

  uart_tx_8n1 #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy4), .tx(tx4), .busy(busy4), .done(done4)
  );

  uart_tx_8n1 #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy2), .tx(tx2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: a frame is 10 bits {stop, data, start}; pos counts enabled cycles since the handshake.
  int         nclk[2] = '{4, 2};
  int         pos[2] = '{0, 0};
  logic [9:0] frame[2];
  int         hs_tick[2];
  int         done_tick[2];
  int         done_cnt[2];
  int         hs4[$];
  int         hs2[$];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0h expected %0h at cycle %0d", tag, d, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic o_tx[2], o_busy[2], o_done[2], o_rdy[2];
    logic e_tx;
    @(negedge clk);
    o_tx   = '{tx4, tx2};
    o_busy = '{busy4, busy2};
    o_done = '{done4, done2};
    o_rdy  = '{rdy4, rdy2};
    for (int i = 0; i < 2; i++) begin
      if (rst) pos[i] = 0;
      e_tx = (pos[i] == 0) ? 1'b1 : frame[i][(pos[i] - 1) / nclk[i]];
      chk("tx", i, 32'(o_tx[i]), 32'(e_tx));
      chk("busy", i, 32'(o_busy[i]), 32'(pos[i] != 0));
      chk("done", i, 32'(o_done[i]), 32'(ena && !rst && pos[i] == 10 * nclk[i]));
      chk("tx_ready", i, 32'(o_rdy[i]), 32'(pos[i] == 0 && ena && !rst));
      if (o_done[i] === 1'b1) begin
        done_tick[i] = cyc;
        done_cnt[i]++;
      end
      if (o_rdy[i] === 1'b1 && tx_valid) begin
        if (i == 0) hs4.push_back(cyc);
        else        hs2.push_back(cyc);
      end
      if (!rst && ena) begin
        if (pos[i] == 0) begin
          if (tx_valid) begin
            pos[i]     = 1;
            frame[i]   = {1'b1, tx_data, 1'b0};
            hs_tick[i] = cyc;
          end
        end else if (pos[i] == 10 * nclk[i]) begin
          pos[i] = 0;
        end else begin
          pos[i]++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((pos[0] != 0 || pos[1] != 0) && budget < 200) begin
      tick();
      budget++;
    end
    if (pos[0] != 0 || pos[1] != 0) begin
      checks++;
      errors++;
      $error("FAIL idle_timeout observed busy expected idle within 200 cycles");
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    // reset with random inputs
    for (int k = 0; k < 4; k++) begin
      ena      = 1'($urandom);
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      tick();
    end
    rst = 1'b0; ena = 1'b1; tx_valid = 1'b0;
    run(3);

    // single byte 0xA5
    done_cnt = '{0, 0};
    send(8'hA5);
    run(45);
    chk("a5_done_latency", 0, 32'(done_tick[0] - hs_tick[0]), 32'd40);
    chk("a5_done_pulses", 0, 32'(done_cnt[0]), 32'd1);
    chk("a5_done_latency", 1, 32'(done_tick[1] - hs_tick[1]), 32'd20);
    wait_idle();

    // valid held through the frame
    hs4.delete();
    tx_valid = 1'b1; tx_data = 8'h3C;
    tick();
    tx_data = 8'hFF;
    run(50);
    tx_valid = 1'b0;
    wait_idle();
    chk("busy_valid_hs_count", 0, 32'(hs4.size()), 32'd2);
    if (hs4.size() >= 2) chk("busy_valid_hs_gap", 0, 32'(hs4[1] - hs4[0]), 32'd41);

    // ena gap inside data bit 0
    send(8'h01);
    run(5);
    ena = 1'b0;
    run(5);
    ena = 1'b1;
    run(45);
    chk("ena_gap_done_latency", 0, 32'(done_tick[0] - hs_tick[0]), 32'd45);
    wait_idle();

    // reset during data bit 3 of 0x00
    send(8'h00);
    run(17);
    rst = 1'b1;
    #1;
    chk("rst_tx_async", 0, 32'(tx4), 32'd1);
    run(2);
    rst = 1'b0;
    run(2);
    send(8'h81);
    run(45);
    wait_idle();

    // back-to-back stream on the N=2 instance
    begin
      logic [7:0] bytes[3];
      int n_acc, budget;
      bytes = '{8'h55, 8'hAA, 8'h0F};
      hs2.delete();
      n_acc = 0; budget = 0;
      tx_valid = 1'b1; tx_data = bytes[0];
      while (n_acc < 3 && budget < 200) begin
        tick();
        budget++;
        if (hs2.size() > n_acc) begin
          n_acc = hs2.size();
          if (n_acc < 3) tx_data = bytes[n_acc];
        end
      end
      tx_valid = 1'b0;
      chk("b2b_accepted", 1, 32'(n_acc), 32'd3);
      if (hs2.size() == 3) begin
        chk("b2b_period", 1, 32'(hs2[1] - hs2[0]), 32'd21);
        chk("b2b_period", 1, 32'(hs2[2] - hs2[1]), 32'd21);
      end
      wait_idle();
    end

    // randomized traffic with enable gaps and occasional resets
    for (int k = 0; k < 600; k++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      ena      = ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; ena = 1'b1; tx_valid = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
